// File: rtl/pwm_ctrl_pkg.sv
// Shared types and saturating duty arithmetic for the PWM duty scheduler.
package pwm_ctrl_pkg;

  localparam int DUTY_W    = 11;
  localparam int OVR_CNT_W = 4;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } sched_state_t;

  // Add with one guard bit; clamp to full scale instead of wrapping.
  function automatic duty_t sat_add(input duty_t a, input duty_t b);
    logic [DUTY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DUTY_W] ? {DUTY_W{1'b1}} : sum[DUTY_W-1:0];
  endfunction

  // Subtract with one guard bit; a borrow means the result went negative, clamp to 0.
  function automatic duty_t sat_sub(input duty_t a, input duty_t b);
    logic [DUTY_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[DUTY_W] ? {DUTY_W{1'b0}} : diff[DUTY_W-1:0];
  endfunction

  function automatic duty_t min_duty(input duty_t a, input duty_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ovr_i_monitor.sv
// Over-current monitor: blank-qualified per-period flag, consecutive-period
// counter and a trip pulse on the synch that completes the OVR_LIMIT-th bad period.
module ovr_i_monitor
  import pwm_ctrl_pkg::*;
#(
  parameter int OVR_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic synch,
  input  logic blank_n,
  input  logic ovr_i,
  input  logic freeze,
  input  logic clr,
  output logic period_ovr,
  output logic trip
);

  localparam logic [OVR_CNT_W-1:0] CNT_TRIP = OVR_CNT_W'(OVR_LIMIT - 1);
  localparam logic [OVR_CNT_W-1:0] CNT_MAX  = OVR_CNT_W'(OVR_LIMIT);

  logic                 ovr_seen;
  logic [OVR_CNT_W-1:0] ovr_cnt;
  logic                 hit;

  // Comparator events outside the blanking window are real; inside they are switching noise.
  assign hit = ovr_i & blank_n;

  // A hit on the synch cycle itself still belongs to the period that is ending.
  assign period_ovr = synch & (ovr_seen | hit);

  // Trip on the synch that would take the count to the limit.
  assign trip = period_ovr & ~freeze & (ovr_cnt == CNT_TRIP);

  // Sticky per-period over-current flag, cleared at every period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      ovr_seen <= 1'b0;
    end else if (synch) begin
      ovr_seen <= 1'b0;
    end else if (hit) begin
      ovr_seen <= 1'b1;
    end
  end

  // Consecutive over-current period counter; frozen while faulted, cleared on fault exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (clr) begin
      ovr_cnt <= '0;
    end else if (synch && !freeze) begin
      if (period_ovr) begin
        ovr_cnt <= (ovr_cnt == CNT_MAX) ? ovr_cnt : ovr_cnt + 1'b1;
      end else begin
        ovr_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sched.sv
// PWM duty scheduler: latches target requests, ramps the applied duty toward
// the effective target once per PWM period and shuts down on repeated over-current.
module pwm_duty_sched
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP_UP     = 16,
  parameter int STEP_DN     = 32,
  parameter int OVR_LIMIT   = 3,
  parameter int OVR_BACKOFF = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_vld,
  output logic              tgt_rdy,
  input  logic              PWM_synch,
  input  logic              blank_n,
  input  logic              OVR_I,
  input  logic              clr_fault,
  output logic [DUTY_W-1:0] duty,
  output logic              ramping,
  output logic              fault
);

  localparam duty_t STEP_UP_D = duty_t'(STEP_UP);
  localparam duty_t STEP_DN_D = duty_t'(STEP_DN);
  localparam duty_t BACKOFF_D = duty_t'(OVR_BACKOFF);

  sched_state_t state;
  sched_state_t ramp_state;
  duty_t        tgt_q;
  duty_t        eff_tgt;
  duty_t        inc;
  duty_t        dec;
  duty_t        ramp_duty;
  duty_t        backoff_duty;
  logic         fault_exit;
  logic         accept;
  logic         period_ovr;
  logic         trip;
  logic         in_fault;

  assign in_fault   = (state == FAULT);
  assign fault_exit = in_fault & clr_fault & ~en;
  // Fault entry on the same edge discards a concurrent target handshake.
  assign accept     = tgt_vld & tgt_rdy & ~trip;

  ovr_i_monitor #(
    .OVR_LIMIT (OVR_LIMIT)
  ) u_ovr_i_monitor (
    .clk        (clk),
    .rst_n      (rst_n),
    .synch      (PWM_synch),
    .blank_n    (blank_n),
    .ovr_i      (OVR_I),
    .freeze     (in_fault),
    .clr        (fault_exit),
    .period_ovr (period_ovr),
    .trip       (trip)
  );

  // Ramp/backoff datapath: candidate next duty values and where a ramp step lands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_tgt      = en ? tgt_q : '0;
    inc          = min_duty(STEP_UP_D, eff_tgt - duty);
    dec          = min_duty(STEP_DN_D, duty - eff_tgt);
    ramp_duty    = duty;
    backoff_duty = sat_sub(duty, BACKOFF_D);
    ramp_state   = RAMP;

    if (duty < eff_tgt) begin
      ramp_duty = sat_add(duty, inc);
    end else if (duty > eff_tgt) begin
      ramp_duty = sat_sub(duty, dec);
    end

    if (ramp_duty == eff_tgt) begin
      ramp_state = (eff_tgt != '0) ? HOLD : IDLE;
    end
  end

  // Target register: latest accepted request wins; cleared when leaving FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
    end else if (fault_exit) begin
      tgt_q <= '0;
    end else if (accept) begin
      tgt_q <= tgt_duty;
    end
  end

  // Scheduler FSM with registered duty, status and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      duty    <= '0;
      ramping <= 1'b0;
      fault   <= 1'b0;
      tgt_rdy <= 1'b0;
    end else begin
      case (state)
        FAULT: begin
          duty <= '0;
          if (fault_exit) begin
            state   <= IDLE;
            fault   <= 1'b0;
            tgt_rdy <= 1'b1;
          end
        end
        default: begin
          tgt_rdy <= 1'b1;
          if (trip) begin
            // Fault entry overrides backoff, ramp and target accept.
            state   <= FAULT;
            duty    <= '0;
            ramping <= 1'b0;
            fault   <= 1'b1;
            tgt_rdy <= 1'b0;
          end else if (period_ovr) begin
            // Over-current period: back off instead of stepping this period.
            duty    <= backoff_duty;
            state   <= RAMP;
            ramping <= 1'b1;
          end else if (PWM_synch && state != HOLD) begin
            // IDLE and RAMP both take a step at the period boundary; a zero step settles.
            duty    <= ramp_duty;
            state   <= ramp_state;
            ramping <= (ramp_state == RAMP);
          end else if (state == HOLD && eff_tgt != duty) begin
            // Target moved away: resume ramping from the next period boundary.
            state   <= RAMP;
            ramping <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
